// File: rtl/axi_rd_pkg.sv
// Shared definitions for the strided AXI read master: FSM state codes and err bit positions.
package axi_rd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int ERR_EARLY_LAST   = 0;
  localparam int ERR_MISSING_LAST = 1;
  localparam int ERR_ID_MISMATCH  = 2;

endpackage

// File: rtl/axi_stride_read_master_if.sv
// AR and R channel bundle between the strided read master and the downstream prefetcher.
interface axi_stride_read_master_if #(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 4,
  parameter int DATA_W          = 64
);
  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;
  logic                       m_r_valid;
  logic                       m_r_ready;
  logic [DATA_W-1:0]          m_r_data;
  logic                       m_r_last;
  logic [TID_WIDTH-1:0]       m_r_id;

  modport master (
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );

  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );
endinterface

// File: rtl/axi_rd_ts_fifo.sv
// Timestamp FIFO: holds the AR-issue cycle of each in-flight burst until its first R beat.
module axi_rd_ts_fifo #(
  parameter int LOG_DEPTH = 2,
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_reg;
  logic [LOG_DEPTH:0] rd_ptr_reg;
  logic               full;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[LOG_DEPTH] != rd_ptr_reg[LOG_DEPTH]) &&
                    (wr_ptr_reg[LOG_DEPTH-1:0] == rd_ptr_reg[LOG_DEPTH-1:0]);
  assign pop_data = mem[rd_ptr_reg[LOG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr_reg[LOG_DEPTH-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/axi_stride_read_master.sv
// Strided AXI4 read master: issues cfg_count bursts at base + k*stride with bounded outstanding
// bursts and checks returned beats. Define STRIDE_RD_LATENCY_EN to add lat_max/lat_sum outputs.
module axi_stride_read_master
  import axi_rd_pkg::*;
#(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 4,
  parameter int LOG_BLOCK_DATA_BYTES = 3,
  parameter int LOG_MAX_OUTST        = 2,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_BITS-1:0]                  cfg_base,
  input  logic [ADDR_BITS-1:0]                  cfg_stride,
  input  logic [CNT_WIDTH-1:0]                  cfg_count,
  input  logic [BURST_LEN_WIDTH-1:0]            cfg_len,
  input  logic [TID_WIDTH-1:0]                  cfg_id,
  output logic                                  busy,
  output logic                                  done,
  axi_stride_read_master_if.master              m_axi,
  output logic [CNT_WIDTH-1:0]                  beat_cnt,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  last_data,
  output logic [2:0]                            err
`ifdef STRIDE_RD_LATENCY_EN
  ,
  output logic [CNT_WIDTH-1:0]                  lat_max,
  output logic [CNT_WIDTH-1:0]                  lat_sum
`endif
);
  localparam int DATA_W  = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int OUTST_W = LOG_MAX_OUTST + 1;
  localparam logic [OUTST_W-1:0] MAX_OUTST = OUTST_W'(1 << LOG_MAX_OUTST);

  logic [1:0]                 state_reg, state_next;
  logic [ADDR_BITS-1:0]       stride_reg;
  logic [CNT_WIDTH-1:0]       count_reg;
  logic [BURST_LEN_WIDTH-1:0] len_reg;
  logic [TID_WIDTH-1:0]       id_reg;
  logic [ADDR_BITS-1:0]       addr_reg;
  logic [CNT_WIDTH-1:0]       issued_reg, issued_next;
  logic [OUTST_W-1:0]         outst_reg, outst_next;
  logic [BURST_LEN_WIDTH-1:0] beat_idx_reg;
  logic                       ar_valid_reg, ar_valid_next;
  logic [CNT_WIDTH-1:0]       beat_cnt_reg;
  logic [DATA_W-1:0]          last_data_reg;
  logic [2:0]                 err_reg, err_set;

  logic                 start_ok, ar_hs, r_ready, r_hs, r_counted, first_beat;
  logic                 last_expected, burst_close;
  logic [CNT_WIDTH-1:0] count_sel;

  assign start_ok      = start && (state_reg == ST_IDLE);
  assign ar_hs         = ar_valid_reg && m_axi.m_ar_ready;
  assign r_ready       = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
  assign r_hs          = m_axi.m_r_valid && r_ready;
  assign r_counted     = r_hs && (outst_reg != '0);
  assign first_beat    = r_counted && (beat_idx_reg == '0);
  assign last_expected = (beat_idx_reg == len_reg);
  // A burst closes on its last flag or on its final expected beat, whichever comes first.
  assign burst_close   = r_counted && (m_axi.m_r_last || last_expected);
  assign count_sel     = start_ok ? cfg_count : count_reg;
  assign issued_next   = start_ok ? '0 : issued_reg + CNT_WIDTH'(ar_hs);
  assign outst_next    = outst_reg + OUTST_W'(ar_hs) - OUTST_W'(burst_close);

  always_comb begin
    err_set                   = '0;
    err_set[ERR_EARLY_LAST]   = burst_close && m_axi.m_r_last && !last_expected;
    err_set[ERR_MISSING_LAST] = (r_counted && last_expected && !m_axi.m_r_last) ||
                                (r_hs && (outst_reg == '0));
    err_set[ERR_ID_MISMATCH]  = r_hs && (m_axi.m_r_id != id_reg);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (cfg_count == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (ar_hs && (issued_next == count_reg)) state_next = ST_DRAIN;
      ST_DRAIN: if (outst_reg == '0) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Once raised, valid can only drop via a handshake: outstanding never grows without one.
  assign ar_valid_next = (state_next == ST_ISSUE) && (issued_next < count_sel) &&
                         (outst_next < MAX_OUTST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      stride_reg    <= '0;
      count_reg     <= '0;
      len_reg       <= '0;
      id_reg        <= '0;
      addr_reg      <= '0;
      issued_reg    <= '0;
      outst_reg     <= '0;
      beat_idx_reg  <= '0;
      ar_valid_reg  <= 1'b0;
      beat_cnt_reg  <= '0;
      last_data_reg <= '0;
      err_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      ar_valid_reg <= ar_valid_next;
      issued_reg   <= issued_next;
      outst_reg    <= outst_next;
      if (start_ok) begin
        stride_reg   <= cfg_stride;
        count_reg    <= cfg_count;
        len_reg      <= cfg_len;
        id_reg       <= cfg_id;
        addr_reg     <= cfg_base;
        beat_idx_reg <= '0;
        beat_cnt_reg <= '0;
        err_reg      <= '0;
      end else begin
        if (ar_hs) addr_reg <= addr_reg + stride_reg;
        if (burst_close) beat_idx_reg <= '0;
        else if (r_counted) beat_idx_reg <= beat_idx_reg + 1'b1;
        if (r_counted) begin
          beat_cnt_reg  <= beat_cnt_reg + 1'b1;
          last_data_reg <= m_axi.m_r_data;
        end
        err_reg <= err_reg | err_set;
      end
    end
  end

  assign busy             = (state_reg != ST_IDLE);
  assign done             = (state_reg == ST_DONE);
  assign beat_cnt         = beat_cnt_reg;
  assign last_data        = last_data_reg;
  assign err              = err_reg;
  assign m_axi.m_ar_valid = ar_valid_reg;
  assign m_axi.m_ar_addr  = addr_reg;
  assign m_axi.m_ar_len   = len_reg;
  assign m_axi.m_ar_id    = id_reg;
  assign m_axi.m_r_ready  = r_ready;

`ifdef STRIDE_RD_LATENCY_EN
  logic [CNT_WIDTH-1:0] cyc_reg, stamp, lat_now, lat_max_reg, lat_sum_reg;
  logic                 ts_empty, lat_pop;

  assign lat_pop = first_beat && !ts_empty;
  assign lat_now = cyc_reg - stamp;

  axi_rd_ts_fifo #(
    .LOG_DEPTH (LOG_MAX_OUTST),
    .WIDTH     (CNT_WIDTH)
  ) u_ts_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .push      (ar_hs),
    .push_data (cyc_reg),
    .pop       (lat_pop),
    .pop_data  (stamp),
    .empty     (ts_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg     <= '0;
      lat_max_reg <= '0;
      lat_sum_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 1'b1;
      if (start_ok) begin
        lat_max_reg <= '0;
        lat_sum_reg <= '0;
      end else if (lat_pop) begin
        lat_sum_reg <= lat_sum_reg + lat_now;
        if (lat_now > lat_max_reg) lat_max_reg <= lat_now;
      end
    end
  end

  assign lat_max = lat_max_reg;
  assign lat_sum = lat_sum_reg;
`endif
endmodule
